pipe_stall_ctrl: RTL and testbench

//   Central stall/flush controller for the 5-stage 16-bit pipeline. Drives the

---
 rtl/pipe_stall_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: register write enables,
// data-memory req/ack sequencing, load-use bubbles, branch squash, timeout.
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_load,
    input  logic             mem_store,
    input  logic             mem_ack,
    input  logic             ex_load,
    input  logic [2:0]       ex_rdest_addr,
    input  logic [2:0]       id_rs1_addr,
    input  logic [2:0]       id_rs2_addr,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             branch_taken,
    output logic             pc_wen,
    output logic             IFtoID_Wen,
    output logic             IDtoEX_Wen,
    output logic             EXtoMEM_Wen,
    output logic             MEMtoWB_Wen,
    output logic             IFtoID_flush,
    output logic             IDtoEX_bubble,
    output logic             mem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       fsm_state
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam int              WC_W     = $clog2(TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST  = WC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]      state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [4:0]      wen;
    logic            mem_op;
    logic            load_use;

    assign mem_op   = mem_load | mem_store;
    assign load_use = ex_load & ((id_use_rs1 & (id_rs1_addr == ex_rdest_addr)) |
                                 (id_use_rs2 & (id_rs2_addr == ex_rdest_addr)));

    assign {pc_wen, IFtoID_Wen, IDtoEX_Wen, EXtoMEM_Wen, MEMtoWB_Wen} = wen;
    assign fsm_state = state;

    // Memory handshake: mem_req rises with the op in MEM and holds until the
    // cycle mem_ack is seen; an ack in the request cycle completes with no stall.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        wen           = 5'b00000;
        IFtoID_flush  = 1'b0;
        IDtoEX_bubble = 1'b0;
        mem_req       = 1'b0;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    mem_req = mem_op;
                    if (mem_op && !mem_ack) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = '0;
                    end else if (branch_taken) begin
                        wen           = 5'b11111;
                        IFtoID_flush  = 1'b1;
                        IDtoEX_bubble = 1'b1;
                    end else if (load_use) begin
                        wen           = 5'b00111;
                        IDtoEX_bubble = 1'b1;
                    end else begin
                        wen = 5'b11111;
                    end
                end
                ST_WAIT: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        wen          = 5'b11111;
                        state_nxt    = ST_RUN;
                        wait_cnt_nxt = '0;
                    end else if (wait_cnt == WC_LAST) begin
                        state_nxt = ST_ERR;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end
                end
                default: state_nxt = ST_ERR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= mem_err | (state_nxt == ST_ERR);
            if (!pc_wen && (stall_cycles != CNT_MAX))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized plus directed bench for pipe_stall_ctrl against a cycle-level
// behavioural model of the pipeline stall rules.
module tb_pipe_stall_ctrl;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;
    localparam int W       = 8 + 1 + CNT_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_load, mem_store, mem_ack, ex_load;
    logic [2:0]       ex_rdest_addr, id_rs1_addr, id_rs2_addr;
    logic             id_use_rs1, id_use_rs2, branch_taken;
    logic             pc_wen, IFtoID_Wen, IDtoEX_Wen, EXtoMEM_Wen, MEMtoWB_Wen;
    logic             IFtoID_flush, IDtoEX_bubble, mem_req, mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0]       fsm_state;

    pipe_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .mem_load(mem_load), .mem_store(mem_store), .mem_ack(mem_ack),
        .ex_load(ex_load), .ex_rdest_addr(ex_rdest_addr),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .branch_taken(branch_taken),
        .pc_wen(pc_wen), .IFtoID_Wen(IFtoID_Wen), .IDtoEX_Wen(IDtoEX_Wen),
        .EXtoMEM_Wen(EXtoMEM_Wen), .MEMtoWB_Wen(MEMtoWB_Wen),
        .IFtoID_flush(IFtoID_flush), .IDtoEX_bubble(IDtoEX_bubble),
        .mem_req(mem_req), .mem_err(mem_err), .stall_cycles(stall_cycles),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // model: is an access outstanding, how many extra cycles it has waited,
    // has the pipeline died on a timeout, and how many frozen-PC cycles so far
    bit m_busy, m_dead, m_err;
    int m_waited, m_stalls;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {pc, ifid, idex, exmem, memwb, flush, bubble, req}
    function automatic logic [7:0] model_ctrl();
        bit lu;
        bit mop;
        lu  = ex_load && ((id_use_rs1 && id_rs1_addr == ex_rdest_addr) ||
                          (id_use_rs2 && id_rs2_addr == ex_rdest_addr));
        mop = mem_load || mem_store;
        if (reset || m_dead)      return 8'b00000_0_0_0;
        if (m_busy)               return mem_ack ? 8'b11111_0_0_1 : 8'b00000_0_0_1;
        if (mop && !mem_ack)      return 8'b00000_0_0_1;
        if (branch_taken)         return {5'b11111, 2'b11, mop};
        if (lu)                   return {5'b00111, 2'b01, mop};
        return {5'b11111, 2'b00, mop};
    endfunction

    task automatic model_step(input logic pc);
        if (reset) begin
            m_busy = 0; m_dead = 0; m_err = 0; m_waited = 0; m_stalls = 0;
        end else begin
            if (!pc && m_stalls < (1 << CNT_W) - 1) m_stalls++;
            if (m_dead) begin
            end else if (m_busy) begin
                if (mem_ack) m_busy = 0;
                else begin
                    m_waited++;
                    if (m_waited == TIMEOUT) begin m_dead = 1; m_err = 1; end
                end
            end else if ((mem_load || mem_store) && !mem_ack) begin
                m_busy = 1; m_waited = 0;
            end
        end
    endtask

    // driver tasks
    task automatic clear_inputs();
        mem_load = 0; mem_store = 0; mem_ack = 0; ex_load = 0;
        ex_rdest_addr = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; branch_taken = 0;
    endtask

    task automatic cycle();
        logic [W-1:0] e;
        logic [7:0]   ctrl;
        @(negedge clk);
        ctrl = model_ctrl();
        exp_q.push_back({ctrl, m_err, CNT_W'(m_stalls)});
        e = exp_q.pop_front();
        check("ctrl", 32'({pc_wen, IFtoID_Wen, IDtoEX_Wen, EXtoMEM_Wen, MEMtoWB_Wen,
                           IFtoID_flush, IDtoEX_bubble, mem_req}), 32'(e[W-1 -: 8]));
        check("mem_err", 32'(mem_err), 32'(e[CNT_W]));
        check("stall_cycles", 32'(stall_cycles), 32'(e[CNT_W-1:0]));
        @(posedge clk);
        model_step(ctrl[7]);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic rand_inputs();
        int r;
        r = $urandom_range(0, 9);
        mem_load      = (r < 2);
        mem_store     = (r == 2);
        mem_ack       = ($urandom_range(0, 9) < 4);
        ex_load       = ($urandom_range(0, 1) == 1);
        ex_rdest_addr = 3'($urandom_range(0, 3));
        id_rs1_addr   = 3'($urandom_range(0, 3));
        id_rs2_addr   = 3'($urandom_range(0, 3));
        id_use_rs1    = ($urandom_range(0, 1) == 1);
        id_use_rs2    = ($urandom_range(0, 1) == 1);
        branch_taken  = ($urandom_range(0, 9) == 0);
        reset         = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        m_busy = 0; m_dead = 0; m_err = 0; m_waited = 0; m_stalls = 0;
        clear_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        cycle();
        reset = 0;

        // zero-wait access
        mem_load = 1; mem_ack = 1;
        cycle();
        clear_inputs();
        cycle();

        // store acked after three stalled cycles
        do_reset();
        mem_store = 1;
        repeat (3) cycle();
        mem_ack = 1;
        cycle();
        clear_inputs();
        check("store_stall_count", 32'(stall_cycles), 32'd3);

        // load-use hazard through rs2, then same operands with rs2 unused
        ex_load = 1; ex_rdest_addr = 3; id_rs2_addr = 3; id_use_rs2 = 1; id_rs1_addr = 5;
        cycle();
        id_use_rs2 = 0;
        cycle();
        clear_inputs();

        // branch held across a memory stall
        mem_load = 1; branch_taken = 1;
        repeat (2) cycle();
        mem_ack = 1;
        cycle();
        mem_load = 0; mem_ack = 0;
        cycle();
        clear_inputs();

        // timeout into the error state, which ignores a late ack
        do_reset();
        mem_load = 1;
        repeat (1 + TIMEOUT) cycle();
        check("timeout_err", 32'(mem_err), 32'd1);
        mem_ack = 1;
        repeat (2) cycle();
        check("err_sticky", 32'(mem_err), 32'd1);

        // ack on the last allowed wait cycle
        do_reset();
        check("err_cleared", 32'(mem_err), 32'd0);
        mem_load = 1;
        repeat (TIMEOUT) cycle();
        mem_ack = 1;
        cycle();
        clear_inputs();
        cycle();
        check("late_ack_no_err", 32'(mem_err), 32'd0);

        // reset in the middle of a wait
        mem_store = 1;
        repeat (4) cycle();
        reset = 1;
        cycle();
        reset = 0; mem_store = 0;
        cycle();

        // stall counter saturation
        do_reset();
        mem_load = 1;
        repeat (1 + TIMEOUT + 300) cycle();
        check("stall_saturate", 32'(stall_cycles), 32'd255);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end
        reset = 0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
